// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative binary32 divider z = a / b, one restoring quotient bit per cycle.
// Define FP_DIV_EARLY_OUT_EN to let special operands skip DIVIDE/ROUND via SPECIAL.
package rnd_enum;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;
endpackage

module fp_div_seq
    import rnd_enum::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [7:0]  status
);
    typedef enum logic [2:0] {IDLE, PREP, DIVIDE, ROUND, SPECIAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [2:0]         rnd_q, rnd_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        dvs_q, dvs_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               spc_q, spc_d;
    logic [31:0]        res_z_q, res_z_d, z_q, z_d;
    logic [7:0]         res_st_q, res_st_d, status_q, status_d;
    logic               done_q, done_d, busy_q, busy_d;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, op_sign;
    logic spc_hit;
    logic [31:0] spc_z;
    logic [7:0]  spc_st;

    assign a_zero  = a_q[30:23] == 8'h00;
    assign b_zero  = b_q[30:23] == 8'h00;
    assign a_inf   = a_q[30:23] == 8'hFF && a_q[22:0] == 23'd0;
    assign b_inf   = b_q[30:23] == 8'hFF && b_q[22:0] == 23'd0;
    assign a_nan   = a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0;
    assign b_nan   = b_q[30:23] == 8'hFF && b_q[22:0] != 23'd0;
    assign op_sign = a_q[31] ^ b_q[31];

    // Priority order matters: inf/0 is an infinite dividend, not a divide-by-zero.
    always_comb begin
        spc_hit = 1'b1;
        spc_z   = 32'd0;
        spc_st  = 8'h00;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spc_z  = 32'h7FC0_0000;
            spc_st = 8'h20;
        end else if (b_zero && !a_inf) begin
            spc_z  = {op_sign, 8'hFF, 23'd0};
            spc_st = 8'h42;
        end else if (a_inf) begin
            spc_z  = {op_sign, 8'hFF, 23'd0};
            spc_st = 8'h40;
        end else if (a_zero || b_inf) begin
            spc_z  = {op_sign, 31'd0};
            spc_st = 8'h80;
        end else begin
            spc_hit = 1'b0;
        end
    end

    logic        ge;
    logic [23:0] trial;

    assign ge    = rem_q >= {1'b0, dvs_q};
    assign trial = rem_q[23:0] - dvs_q;

    logic              hi, guard, sticky, inexact, inc, away;
    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_r;
    logic [31:0]       rnd_z;
    logic [7:0]        rnd_st;

    always_comb begin
        hi      = quo_q[25];
        mant    = hi ? quo_q[25:2] : quo_q[24:1];
        guard   = hi ? quo_q[1] : quo_q[0];
        sticky  = (hi & quo_q[0]) | (rem_q != 25'd0);
        inexact = guard | sticky;
        inc     = rnd_q == IEEE_near ? guard & (sticky | mant[0]) :
                  rnd_q == IEEE_pinf ? inexact & ~sign_q :
                  rnd_q == IEEE_ninf ? inexact & sign_q :
                  rnd_q == near_up   ? guard :
                  rnd_q == away_zero ? inexact : 1'b0;
        away    = rnd_q == IEEE_near || rnd_q == near_up || rnd_q == away_zero ||
                  (rnd_q == IEEE_pinf && !sign_q) || (rnd_q == IEEE_ninf && sign_q);
        mant_r  = {1'b0, mant} + 25'(inc);
        frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        exp_r   = exp_q - 10'(!hi) + 10'(mant_r[24]);
        if (exp_r > 10'sd254) begin
            rnd_z  = away ? {sign_q, 31'h7F80_0000} : {sign_q, 31'h7F7F_FFFF};
            rnd_st = away ? 8'h4C : 8'h0C;
        end else if (exp_r < 10'sd1) begin
            rnd_z  = away ? {sign_q, 31'h0080_0000} : {sign_q, 31'd0};
            rnd_st = away ? 8'h14 : 8'h94;
        end else begin
            rnd_z  = {sign_q, exp_r[7:0], frac};
            rnd_st = {5'd0, inexact, 2'd0};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rnd_d    = rnd_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        spc_d    = spc_q;
        res_z_d  = res_z_q;
        res_st_d = res_st_q;
        z_d      = z_q;
        status_d = status_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                rnd_d   = rnd;
                state_d = PREP;
            end
            PREP: begin
                sign_d   = op_sign;
                exp_d    = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                rem_d    = {2'b01, a_q[22:0]};
                dvs_d    = {1'b1, b_q[22:0]};
                quo_d    = 26'd0;
                cnt_d    = 5'd0;
                spc_d    = spc_hit;
                res_z_d  = spc_z;
                res_st_d = spc_st;
`ifdef FP_DIV_EARLY_OUT_EN
                state_d  = spc_hit ? SPECIAL : DIVIDE;
`else
                state_d  = DIVIDE;
`endif
            end
            DIVIDE: begin
                rem_d   = ge ? {trial, 1'b0} : {rem_q[23:0], 1'b0};
                quo_d   = {quo_q[24:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd25 ? ROUND : DIVIDE;
            end
            ROUND: begin
                if (!spc_q) begin
                    res_z_d  = rnd_z;
                    res_st_d = rnd_st;
                end
                state_d = DONE;
            end
            SPECIAL: state_d = DONE;
            DONE: begin
                z_d      = res_z_q;
                status_d = res_st_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE || state_q == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            spc_q    <= 1'b0;
            res_z_q  <= '0;
            res_st_q <= '0;
            z_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rnd_q    <= rnd_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            spc_q    <= spc_d;
            res_z_q  <= res_z_d;
            res_st_q <= res_st_d;
            z_q      <= z_d;
            status_q <= status_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign z      = z_q;
    assign status = status_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed and randomized checks of fp_div_seq against an integer-arithmetic reference.
module tb_fp_div_seq;
    import rnd_enum::*;

`ifdef FP_DIV_EARLY_OUT_EN
    localparam int SPL = 3;
`else
    localparam int SPL = 29;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  rnd = '0;
    logic        busy, done;
    logic [31:0] z;
    logic [7:0]  status;
    int total = 0, bad = 0, done_cnt = 0;

    fp_div_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .rnd(rnd),
                    .busy(busy), .done(done), .z(z), .status(status));

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Quotient from exact integer division of the significands, then the rounding rules.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] r,
                         output logic [31:0] ez, output logic [7:0] es, output bit sp);
        bit sx, xz, yz, xi, yi, xn, yn, g, s, inx, up, away;
        int e;
        longint n, d, q, rm, m;
        sx = x[31] ^ y[31];
        xz = x[30:23] == 8'h00;
        yz = y[30:23] == 8'h00;
        xi = x[30:23] == 8'hFF && x[22:0] == 0;
        yi = y[30:23] == 8'hFF && y[22:0] == 0;
        xn = x[30:23] == 8'hFF && x[22:0] != 0;
        yn = y[30:23] == 8'hFF && y[22:0] != 0;
        sp = 1'b1;
        if (xn || yn || (xz && yz) || (xi && yi)) begin ez = 32'h7FC00000; es = 8'h20; end
        else if (yz && !xi) begin ez = {sx, 31'h7F800000}; es = 8'h42; end
        else if (xi) begin ez = {sx, 31'h7F800000}; es = 8'h40; end
        else if (xz || yi) begin ez = {sx, 31'h0}; es = 8'h80; end
        else begin
            sp = 1'b0;
            n  = longint'({1'b1, x[22:0]});
            d  = longint'({1'b1, y[22:0]});
            q  = (n << 25) / d;
            rm = (n << 25) % d;
            e  = int'(x[30:23]) - int'(y[30:23]) + 127;
            if (q >= 64'd33554432) begin
                m = q / 4; g = q[1]; s = q[0] || rm != 0;
            end else begin
                m = q / 2; g = q[0]; s = rm != 0; e = e - 1;
            end
            inx = g || s;
            case (r)
                IEEE_near: up = g && (s || m[0]);
                IEEE_zero: up = 1'b0;
                IEEE_pinf: up = inx && !sx;
                IEEE_ninf: up = inx && sx;
                near_up:   up = g;
                default:   up = inx;
            endcase
            m = m + (up ? 64'd1 : 64'd0);
            if (m == 64'd16777216) begin m = m / 2; e++; end
            away = r == IEEE_near || r == near_up || r == away_zero ||
                   (r == IEEE_pinf && !sx) || (r == IEEE_ninf && sx);
            if (e > 254) begin
                ez = away ? {sx, 31'h7F800000} : {sx, 31'h7F7FFFFF};
                es = away ? 8'h4C : 8'h0C;
            end else if (e < 1) begin
                ez = away ? {sx, 31'h00800000} : {sx, 31'h0};
                es = away ? 8'h14 : 8'h94;
            end else begin
                ez = {sx, e[7:0], m[22:0]};
                es = inx ? 8'h04 : 8'h00;
            end
        end
    endtask

    function automatic logic [31:0] gen_op();
        int k;
        logic [7:0]  e;
        logic [22:0] m;
        k = $urandom_range(0, 9);
        m = 23'($urandom);
        case (k)
            0: e = 8'h00;
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
            2: e = 8'($urandom_range(1, 20));
            3: e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] r,
                          output logic [31:0] oz, output logic [7:0] ost, output int lat,
                          output logic obusy);
        @(negedge clk);
        a = x; b = y; rnd = r; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        oz = z; ost = status; obusy = busy;
    endtask

    task automatic op_chk(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] r, input logic [31:0] ez, input logic [7:0] es,
                          input int el);
        logic [31:0] oz;
        logic [7:0]  ost;
        int lat;
        logic ob;
        run_op(x, y, r, oz, ost, lat, ob);
        chk({tag, " z"}, oz, ez);
        chk({tag, " status"}, 32'(ost), 32'(es));
        chk({tag, " latency"}, lat, el);
        chk({tag, " busy@done"}, 32'(ob), 32'd1);
    endtask

    initial begin
        logic [31:0] x, y, ez;
        logic [7:0]  es;
        logic [2:0]  r;
        bit sp;
        int c, t1, t2, base;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset z", z, 0);
        chk("reset status", 32'(status), 0);
        rst_n = 1'b1;

        op_chk("one", 32'h3F800000, 32'h3F800000, IEEE_near, 32'h3F800000, 8'h00, 29);
        op_chk("third near", 32'h3F800000, 32'h40400000, IEEE_near, 32'h3EAAAAAB, 8'h04, 29);
        op_chk("third zero", 32'h3F800000, 32'h40400000, IEEE_zero, 32'h3EAAAAAA, 8'h04, 29);
        op_chk("div0", 32'h3F800000, 32'h00000000, IEEE_near, 32'h7F800000, 8'h42, SPL);
        op_chk("ovf near", 32'h7F000000, 32'h3E800000, IEEE_near, 32'h7F800000, 8'h4C, 29);
        op_chk("ovf zero", 32'h7F000000, 32'h3E800000, IEEE_zero, 32'h7F7FFFFF, 8'h0C, 29);
        op_chk("nan", 32'h00000000, 32'h00000000, IEEE_near, 32'h7FC00000, 8'h20, SPL);
        op_chk("unf zero", 32'h00800000, 32'h7F000000, IEEE_zero, 32'h00000000, 8'h94, 29);
        op_chk("unf ninf", 32'h80800000, 32'h7F000000, IEEE_ninf, 32'h80800000, 8'h14, 29);
        @(posedge clk);
        #1 chk("idle busy", 32'(busy), 0);
        chk("idle done", 32'(done), 0);

        // Second start mid-operation must be ignored.
        base = done_cnt;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rnd = IEEE_near; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 0;
        repeat (9) begin @(posedge clk); #1 c++; end
        chk("mid busy", 32'(busy), 1);
        a = 32'h40000000; b = 32'h3F800000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; c++;
        while (!done && c < 100) begin @(posedge clk); #1 c++; end
        chk("ignore latency", c, 29);
        chk("ignore z", z, 32'h3EAAAAAB);
        repeat (40) @(posedge clk);
        #1 chk("ignore done count", done_cnt - base, 1);

        // start held high: the DONE-state request is dropped, the done-cycle request is taken.
        @(negedge clk);
        a = 32'h40000000; b = 32'h3F800000; rnd = IEEE_near; start = 1'b1;
        @(posedge clk);
        #1 c = 0; t1 = -1; t2 = -1;
        while (c < 100 && t2 < 0) begin
            @(posedge clk);
            #1 c++;
            if (done) begin
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
        end
        start = 1'b0;
        chk("b2b first", t1, 29);
        chk("b2b second", t2, 59);
        chk("b2b z", z, 32'h40000000);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rnd = IEEE_near; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort z", z, 0);
        chk("abort status", 32'(status), 0);
        base = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("abort no done", done_cnt - base, 0);
        op_chk("after reset", 32'hC0A00000, 32'h40000000, IEEE_near, 32'hC0200000, 8'h00, 29);

        for (int i = 0; i < 40; i++) begin
            x = gen_op();
            y = gen_op();
            r = 3'($urandom_range(0, 5));
            model(x, y, r, ez, es, sp);
            op_chk($sformatf("rand%0d %h/%h m%0d", i, x, y, r), x, y, r, ez, es, sp ? SPL : 29);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative single-precision IEEE-754 divider: the inverse operation to the team's combinational `fp_mult`, producing `z = a / b`. It uses the same `rnd_enum::rnd_t` rounding modes and the same `status` byte layout, so both units can sit behind one FP issue port. It runs a start/done handshake with one quotient bit per cycle over a fixed-length schedule.

## Interface
- No parameters; format fixed to binary32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `a`, `b` in 32: dividend and divisor; captured on the accepted `start`.
- `rnd` in 3: `rnd_t` mode; captured with the operands.
- `busy` out 1: high from the cycle after acceptance until `done` inclusive.
- `done` out 1: one-cycle pulse; `z` and `status` are valid.
- `z` out 32: result; held until the next `done`.
- `status` out 8: bits [7] zero, [6] inf, [5] nan, [4] tiny, [3] huge, [2] inexact, [1] div_by_zero, [0] always 0; held with `z`.

## Operation
- FSM states and transitions:
  - IDLE → PREP when `start` is sampled high.
  - PREP → DIVIDE, or PREP → SPECIAL when the configured early exit applies.
  - DIVIDE, 26 cycles → ROUND.
  - ROUND → DONE.
  - SPECIAL → DONE.
  - DONE → IDLE.
- PREP:
  - Operands with exponent 0 are flushed to zero.
  - Sign = `a[31]^b[31]`.
  - Exponent = `ea - eb + 127`, held as a 10-bit signed value.
  - Special cases are classified here.
- DIVIDE: restoring division of `{1,ma}` by `{1,mb}`. Each cycle produces one quotient bit, `q[25]` first, weighting `q[25]` as 2^0.
- ROUND, normalization:
  - If `q[25]=1`: mantissa = `q[25:2]`, guard = `q[1]`, sticky = `q[0] | (rem!=0)`.
  - Otherwise: mantissa = `q[24:1]`, guard = `q[0]`, sticky = `rem!=0`, and the exponent is decremented by 1.
- ROUND, rounding:
  - IEEE_near: round to nearest, ties to even.
  - IEEE_zero: truncate.
  - IEEE_pinf: increment if inexact and positive.
  - IEEE_ninf: increment if inexact and negative.
  - near_up: increment if guard.
  - away_zero: increment if inexact.
  - A mantissa carry-out shifts right by 1 and increments the exponent.
- Overflow (exponent > 254) sets huge and inexact. The result is signed inf when rounding away from zero (near, near_up, away_zero, or the directed mode matching the sign). Otherwise the result is the signed max normal `7F7FFFFF`.
- Underflow (exponent < 1) sets tiny and inexact. The result is the signed min normal `00800000` when rounding away from zero. Otherwise it is signed zero.
- Special cases, in priority order:
  1. Either operand NaN, 0/0, or inf/inf → `7FC00000` with nan set.
  2. Finite nonzero divided by 0 → signed inf, with inf and div_by_zero set.
  3. inf/x → signed inf.
  4. 0/x or x/inf → signed zero, with zero set.
- The zero and inf flags also track the normal-path `z`.
- `start` while not in IDLE is ignored; no queuing.

## Timing
- Reset values: `busy=0`, `done=0`, `z=0`, `status=0`, FSM in IDLE.
- Reset mid-operation aborts the operation. No `done` is produced and `z` returns to 0.
- Latency: with `start` sampled at edge k, `done` is high in the cycle following edge k+29. This is 29 cycles, fixed for all operands when the macro is undefined.
- A new `start` is accepted the cycle after `done`, because DONE → IDLE. Throughput is one operation per 30 cycles.
- `start` high in the DONE cycle is ignored.

## Configuration
- `FP_DIV_EARLY_OUT_EN` undefined: special cases still traverse DIVIDE and ROUND with the quotient discarded. Latency is always 29.
- `FP_DIV_EARLY_OUT_EN` defined: PREP branches to SPECIAL on any special case, and `done` arrives 3 cycles after acceptance. Normal operands remain at 29.

## Test plan
- `a=3F800000`, `b=3F800000`, `rnd=IEEE_near` → `z=3F800000`, `status=00`, `done` exactly 29 cycles after `start`.
- `a=3F800000`, `b=40400000`:
  - IEEE_near → `z=3EAAAAAB`, `status=04`.
  - IEEE_zero → `z=3EAAAAAA`, `status=04`.
- `a=3F800000`, `b=00000000` → `z=7F800000`, `status=42`. Latency is 29 with the macro undefined and 3 with it defined.
- `a=7F000000`, `b=3E800000`:
  - IEEE_near → `z=7F800000`, `status=4C`.
  - IEEE_zero → `z=7F7FFFFF`, `status=0C`.
- `start` pulsed again at cycle 10 of an operation → ignored; a single `done` at cycle 29 carrying the first result.
- `rst_n` asserted at cycle 15 → `busy`, `done`, `z`, `status` all 0 immediately and no `done`. A new `start` after release completes normally.
